// File: rtl/i2c_master_tx_engine.sv
// Byte-level I2C master transmit engine.
// A start command produces START and the address byte. Bytes are then drained
// from a first-word-fall-through TX FIFO, each followed by an ACK slot. The
// frame ends with STOP. All timing derives from a quarter-bit tick.
module i2c_master_tx_engine #(
  parameter int PRESCALE_W = 8,
  parameter int DATA_W     = 8
) (
  input  logic                  core_clk,
  input  logic                  core_reset,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [DATA_W-1:0]     addr_byte,
  input  logic                  cmd_start,
  input  logic                  cmd_stop,
  input  logic [DATA_W-1:0]     tx_data,
  input  logic                  tx_empty,
  output logic                  tx_rd_en,
  input  logic                  sda_in,
  output logic                  sda_out,
  output logic                  scl_out,
  output logic                  busy,
  output logic                  done,
  output logic                  ack_err
);

  localparam int                  BIT_CNT_W = $clog2(DATA_W);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_DATA,
    S_ACK,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_tick_cnt;
  logic [1:0]            r_quarter;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0]     r_shift;
  logic                  r_nack;
  logic                  r_sda;
  logic                  r_scl;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ack_err;
  logic                  r_tx_rd_en;
  logic                  w_tick;

  // A quarter-bit ends when the counter reaches the prescale value latched at START.
  assign w_tick = r_busy && (r_tick_cnt == r_prescale);

  // Quarter-bit counter: held at zero while idle so the first quarter is full length.
  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      r_tick_cnt <= '0;
    end else if (!r_busy || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + PRESCALE_W'(1);
    end
  end

  // Frame sequencer: the pin levels for each quarter are registered on the tick that opens it.
  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      r_state    <= S_IDLE;
      r_prescale <= '0;
      r_quarter  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_nack     <= 1'b0;
      r_sda      <= 1'b1;
      r_scl      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ack_err  <= 1'b0;
      r_tx_rd_en <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_tx_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_start) begin
            r_prescale <= prescale;
            r_shift    <= addr_byte;
            r_ack_err  <= 1'b0;
            r_nack     <= 1'b0;
            r_busy     <= 1'b1;
            r_quarter  <= '0;
            r_state    <= S_START;
          end
        end

        // Two quarters with both lines high, then SDA falls with SCL still high.
        S_START: begin
          if (w_tick) begin
            r_quarter <= r_quarter + 2'd1;
            if (r_quarter == 2'd1) begin
              r_sda <= 1'b0;
            end
            if (r_quarter == 2'd3) begin
              r_bit_cnt <= LAST_BIT;
              r_scl     <= 1'b0;
              r_sda     <= r_shift[DATA_W-1];
              r_state   <= S_ADDR;
            end
          end
        end

        // Address and data bytes share the shifter, MSB first.
        S_ADDR, S_DATA: begin
          if (w_tick) begin
            r_quarter <= r_quarter + 2'd1;
            case (r_quarter)
              2'd1: r_scl <= 1'b1;
              2'd3: begin
                r_scl <= 1'b0;
                if (r_bit_cnt == '0) begin
                  r_sda   <= 1'b1;
                  r_nack  <= 1'b0;
                  r_state <= S_ACK;
                end else begin
                  r_bit_cnt <= r_bit_cnt - BIT_CNT_W'(1);
                  r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                  r_sda     <= r_shift[DATA_W-2];
                end
              end
              default: ;
            endcase
          end
        end

        // SDA released; the slave answer is taken on the tick closing the high-SCL quarter.
        S_ACK: begin
          if (w_tick) begin
            r_quarter <= r_quarter + 2'd1;
            case (r_quarter)
              2'd1: r_scl <= 1'b1;
              2'd2: begin
                if (sda_in) begin
                  r_nack    <= 1'b1;
                  r_ack_err <= 1'b1;
                end
              end
              2'd3: begin
                r_scl <= 1'b0;
                if (r_nack || cmd_stop || tx_empty) begin
                  r_sda   <= 1'b0;
                  r_state <= S_STOP;
                end else begin
                  // The head byte is captured on this edge, so the pop that follows is safe.
                  r_tx_rd_en <= 1'b1;
                  r_shift    <= tx_data;
                  r_bit_cnt  <= LAST_BIT;
                  r_sda      <= tx_data[DATA_W-1];
                  r_state    <= S_DATA;
                end
              end
              default: ;
            endcase
          end
        end

        // SCL rises with SDA low, then SDA rises while SCL is high.
        S_STOP: begin
          if (w_tick) begin
            r_quarter <= r_quarter + 2'd1;
            case (r_quarter)
              2'd0: r_scl <= 1'b1;
              2'd1: r_sda <= 1'b1;
              2'd3: begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
              default: ;
            endcase
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sda_out  = r_sda;
  assign scl_out  = r_scl;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ack_err  = r_ack_err;
  assign tx_rd_en = r_tx_rd_en;

endmodule

// File: tb/tb_i2c_master_tx_engine.sv
// Directed bench for i2c_master_tx_engine: a vector table of whole frames
// decoded from the pins, plus a hand-written mid-byte reset sequence.
module tb_i2c_master_tx_engine;

  logic       core_clk = 1'b0;
  logic       core_reset = 1'b1;
  logic [7:0] prescale = 8'd0;
  logic [7:0] addr_byte = 8'd0;
  logic       cmd_start = 1'b0;
  logic       cmd_stop = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_empty = 1'b1;
  logic       tx_rd_en;
  logic       sda_in = 1'b0;
  logic       sda_out;
  logic       scl_out;
  logic       busy;
  logic       done;
  logic       ack_err;

  i2c_master_tx_engine #(.PRESCALE_W(8), .DATA_W(8)) dut (
    .core_clk  (core_clk),
    .core_reset(core_reset),
    .prescale  (prescale),
    .addr_byte (addr_byte),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .tx_data   (tx_data),
    .tx_empty  (tx_empty),
    .tx_rd_en  (tx_rd_en),
    .sda_in    (sda_in),
    .sda_out   (sda_out),
    .scl_out   (scl_out),
    .busy      (busy),
    .done      (done),
    .ack_err   (ack_err)
  );

  always #5 core_clk = ~core_clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model and bus monitor, all sampled on the falling edge.
  logic [7:0] fifo[$];
  logic       bits[$];
  int         rises[$];
  int         cyc = 0;
  int         n_start = 0;
  int         n_stop = 0;
  int         n_pop = 0;
  int         n_done = 0;
  int         busy_cyc = 0;
  int         bad_pop = 0;
  logic       prev_sda = 1'b1;
  logic       prev_scl = 1'b1;

  always @(negedge core_clk) begin
    cyc++;
    if (prev_scl && scl_out && prev_sda && !sda_out) n_start++;
    if (prev_scl && scl_out && !prev_sda && sda_out) begin
      n_stop++;
      // The SCL rise inside STOP is not a data bit.
      if (bits.size() > 0) void'(bits.pop_back());
    end
    if (!prev_scl && scl_out) begin
      bits.push_back(sda_out);
      rises.push_back(cyc);
    end
    if (done) n_done++;
    if (busy) busy_cyc++;
    if (tx_rd_en) begin
      n_pop++;
      if (tx_empty) bad_pop++;
      if (fifo.size() > 0) void'(fifo.pop_front());
      tx_empty = (fifo.size() == 0);
      tx_data  = tx_empty ? 8'h00 : fifo[0];
    end
    prev_sda = sda_out;
    prev_scl = scl_out;
  end

  typedef struct {
    logic [7:0]  pre;
    logic [7:0]  addr;
    int          ndata;
    logic [31:0] data;        // byte i at [8*i +: 8]
    logic        sda;         // slave answer on every ACK slot
    bit          stop_early;  // raise cmd_stop once the first byte is popped
    bit          dup_start;   // second cmd_start (with new prescale/addr) during DATA
    int          exp_nbytes;  // bytes on the bus, address included
    int          exp_pops;
    logic        exp_err;
    int          exp_busy;    // core_clk cycles with busy=1
    int          exp_bit;     // core_clk cycles per bit
    int          exp_left;    // bytes remaining in the FIFO
  } vec_t;

  vec_t vecs[6];

  task automatic clear_monitor();
    bits.delete();
    rises.delete();
    n_start  = 0;
    n_stop   = 0;
    n_pop    = 0;
    n_done   = 0;
    busy_cyc = 0;
    bad_pop  = 0;
  endtask

  task automatic load_fifo(input int n, input logic [31:0] data);
    fifo.delete();
    for (int i = 0; i < n; i++) fifo.push_back(data[8*i +: 8]);
    tx_empty = (fifo.size() == 0);
    tx_data  = tx_empty ? 8'h00 : fifo[0];
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit         timeout;
    bit         dup_done;
    logic [7:0] got;
    logic [7:0] exp;
    string      tag;
    tag = $sformatf("v%0d", idx);
    @(negedge core_clk);
    load_fifo(v.ndata, v.data);
    clear_monitor();
    sda_in    = v.sda;
    prescale  = v.pre;
    addr_byte = v.addr;
    cmd_start = 1'b1;
    @(negedge core_clk);
    cmd_start = 1'b0;
    timeout  = 1'b1;
    dup_done = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge core_clk);
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      if (v.stop_early && n_pop >= 1) cmd_stop = 1'b1;
      if (v.dup_start && n_pop >= 1 && !dup_done) begin
        cmd_start = 1'b1;
        prescale  = 8'h07;
        addr_byte = 8'hFF;
        dup_done  = 1'b1;
      end else begin
        cmd_start = 1'b0;
      end
    end
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    repeat (3) @(negedge core_clk);

    check({tag, " timeout"}, 32'(timeout), 32'd0);
    check({tag, " nbits"}, bits.size(), 9 * v.exp_nbytes);
    if (bits.size() >= 9 * v.exp_nbytes) begin
      for (int k = 0; k < v.exp_nbytes; k++) begin
        for (int b = 0; b < 8; b++) got[7-b] = bits[9*k + b];
        exp = (k == 0) ? v.addr : v.data[8*(k-1) +: 8];
        check($sformatf("%s byte%0d", tag, k), 32'(got), 32'(exp));
        check($sformatf("%s ackslot%0d", tag, k), 32'(bits[9*k + 8]), 32'd1);
      end
    end
    check({tag, " starts"}, n_start, 1);
    check({tag, " stops"}, n_stop, 1);
    check({tag, " pops"}, n_pop, v.exp_pops);
    check({tag, " bad_pop"}, bad_pop, 0);
    check({tag, " done"}, n_done, 1);
    check({tag, " ack_err"}, 32'(ack_err), 32'(v.exp_err));
    check({tag, " busy_cyc"}, busy_cyc, v.exp_busy);
    check({tag, " bit_cyc"}, (rises.size() >= 2) ? rises[1] - rises[0] : -1, v.exp_bit);
    check({tag, " fifo_left"}, fifo.size(), v.exp_left);
    check({tag, " idle_pins"}, {30'd0, sda_out, scl_out}, 32'd3);
  endtask

  initial begin
    //            pre    addr   n  data           sda   stp   dup  nb pops err  busy bit left
    vecs[0] = '{8'd4, 8'hF0, 2, 32'h0000_0201, 1'b0, 1'b0, 1'b0, 3, 2, 1'b0, 580, 20, 0};
    vecs[1] = '{8'd4, 8'hA4, 2, 32'h0000_2211, 1'b1, 1'b0, 1'b0, 1, 0, 1'b1, 220, 20, 2};
    vecs[2] = '{8'd4, 8'h50, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 220, 20, 0};
    vecs[3] = '{8'd2, 8'h3C, 4, 32'h0403_0201, 1'b0, 1'b1, 1'b0, 2, 1, 1'b0, 240, 12, 3};
    vecs[4] = '{8'd0, 8'hA2, 2, 32'h0000_C35A, 1'b0, 1'b0, 1'b1, 3, 2, 1'b0, 116,  4, 0};
    vecs[5] = '{8'd1, 8'hFE, 3, 32'h0080_00FF, 1'b0, 1'b0, 1'b0, 4, 3, 1'b0, 304,  8, 0};

    // Reset state.
    repeat (3) @(negedge core_clk);
    check("rst sda_out", 32'(sda_out), 32'd1);
    check("rst scl_out", 32'(scl_out), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst ack_err", 32'(ack_err), 32'd0);
    check("rst tx_rd_en", 32'(tx_rd_en), 32'd0);
    core_reset = 1'b0;
    repeat (2) @(negedge core_clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset asserted mid-byte: pins release in the same cycle and nothing is popped later.
    begin
      bit reached;
      load_fifo(2, 32'h0000_0201);
      clear_monitor();
      sda_in    = 1'b0;
      prescale  = 8'd4;
      addr_byte = 8'hF0;
      cmd_start = 1'b1;
      @(negedge core_clk);
      cmd_start = 1'b0;
      reached = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        @(negedge core_clk);
        if (bits.size() >= 3 && !scl_out) begin
          reached = 1'b1;
          break;
        end
      end
      check("mid reached", 32'(reached), 32'd1);
      check("mid busy", 32'(busy), 32'd1);
      #2;
      core_reset = 1'b1;
      #1;
      check("mid rst sda_out", 32'(sda_out), 32'd1);
      check("mid rst scl_out", 32'(scl_out), 32'd1);
      check("mid rst busy", 32'(busy), 32'd0);
      repeat (3) @(negedge core_clk);
      core_reset = 1'b0;
      n_pop  = 0;
      n_done = 0;
      repeat (200) @(negedge core_clk);
      check("post rst pops", n_pop, 0);
      check("post rst done", n_done, 0);
      check("post rst busy", 32'(busy), 32'd0);
      check("post rst fifo", fifo.size(), 2);
      check("post rst pins", {30'd0, sda_out, scl_out}, 32'd3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
